// File: rtl/fpu_pkg.sv
// Shared constants, field widths and FSM state encoding for the single-precision add/sub unit.
package fpu_pkg;
  localparam int unsigned EXP_BIAS = 127;
  localparam int unsigned EXP_W    = 8;
  localparam int unsigned FRAC_W   = 23;
  // carry + hidden + 23 fraction + guard + round + sticky
  localparam int unsigned MANT_W   = 28;

  localparam logic [31:0] QNAN    = 32'h7FC00000;
  localparam logic [31:0] POS_INF = 32'h7F800000;
  localparam logic [31:0] NEG_INF = 32'hFF800000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_UNPACK,
    S_ALIGN,
    S_ADD,
    S_NORM,
    S_ROUND,
    S_DONE
  } state_t;
endpackage

// File: rtl/fpu_special_case.sv
// Classifies both operands (B already carries its effective sign) and produces the bypass result
// for NaN, infinity and zero operands; denormals are treated as signed zero.
module fpu_special_case (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        is_special,
  output logic [31:0] result,
  output logic        inv
);
  import fpu_pkg::*;

  logic a_max, b_max, a_zero, b_zero, a_nan, b_nan, a_inf, b_inf;

  always_comb begin
    a_max  = (a[30:23] == '1);
    b_max  = (b[30:23] == '1);
    a_zero = (a[30:23] == '0);
    b_zero = (b[30:23] == '0);
    a_nan  = a_max && (a[22:0] != '0);
    b_nan  = b_max && (b[22:0] != '0);
    a_inf  = a_max && (a[22:0] == '0);
    b_inf  = b_max && (b[22:0] == '0);

    is_special = 1'b1;
    result     = '0;
    inv        = 1'b0;
    if (a_nan || b_nan) begin
      result = QNAN;
      inv    = 1'b1;
    end else if (a_inf && b_inf && (a[31] != b[31])) begin
      result = QNAN;
      inv    = 1'b1;
    end else if (a_inf) begin
      result = a;
    end else if (b_inf) begin
      result = b;
    end else if (a_zero && b_zero) begin
      result = {a[31] & b[31], 31'b0};
    end else if (a_zero) begin
      result = b;
    end else if (b_zero) begin
      result = a;
    end else begin
      is_special = 1'b0;
    end
  end
endmodule

// File: rtl/fpu_addsub_seq.sv
// Multi-cycle IEEE-754 single-precision add/subtract: unpack, align, add, normalize one bit per
// cycle, round-to-nearest-even, then hold the result on a valid/ready handshake.
module fpu_addsub_seq #(
  parameter int unsigned MAX_NORM_STEPS = 26
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        op_sub,
  input  logic [31:0] inp1,
  input  logic [31:0] inp2,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out,
  output logic        flag_ovf,
  output logic        flag_inv
);
  import fpu_pkg::*;

  localparam int unsigned CNT_W = $clog2(MAX_NORM_STEPS + 1);

  state_t              state_q, state_d;
  logic [31:0]         a_q, a_d, b_q, b_d;
  logic                sign_q, sign_d, eff_sub_q, eff_sub_d;
  logic [8:0]          exp_q, exp_d;
  logic [MANT_W-1:0]   mbig_q, mbig_d, msml_q, msml_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [31:0]         res_q, res_d;
  logic                ovf_q, ovf_d, inv_q, inv_d;

  logic                sp_hit, sp_inv;
  logic [31:0]         sp_res;

  fpu_special_case u_special (
    .a          (a_q),
    .b          (b_q),
    .is_special (sp_hit),
    .result     (sp_res),
    .inv        (sp_inv)
  );

  logic                a_ge_b, big_sign;
  logic [30:0]         big, sml;
  logic [7:0]          diff;
  logic [MANT_W-1:0]   sml_full, sml_sh, lost_mask, sum, sum_adj, nrm;
  logic [24:0]         rnd;
  logic [22:0]         rfrac;
  logic                rnd_up;
  logic [8:0]          rexp;

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    sign_d    = sign_q;
    eff_sub_d = eff_sub_q;
    exp_d     = exp_q;
    mbig_d    = mbig_q;
    msml_d    = msml_q;
    cnt_d     = cnt_q;
    res_d     = res_q;
    ovf_d     = ovf_q;
    inv_d     = inv_q;
    a_ge_b    = 1'b0;
    big_sign  = 1'b0;
    big       = '0;
    sml       = '0;
    diff      = '0;
    sml_full  = '0;
    sml_sh    = '0;
    lost_mask = '0;
    sum       = '0;
    sum_adj   = '0;
    nrm       = '0;
    rnd       = '0;
    rfrac     = '0;
    rnd_up    = 1'b0;
    rexp      = '0;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = inp1;
          b_d     = {op_sub ^ inp2[31], inp2[30:0]};
          ovf_d   = 1'b0;
          inv_d   = 1'b0;
          state_d = S_UNPACK;
        end
      end
      S_UNPACK: begin
        if (sp_hit) begin
          res_d   = sp_res;
          inv_d   = sp_inv;
          state_d = S_DONE;
        end else begin
          state_d = S_ALIGN;
        end
      end
      S_ALIGN: begin
        // Magnitude compare on {exp,frac} works because both operands are normal here.
        a_ge_b   = (a_q[30:0] >= b_q[30:0]);
        big      = a_ge_b ? a_q[30:0] : b_q[30:0];
        sml      = a_ge_b ? b_q[30:0] : a_q[30:0];
        big_sign = a_ge_b ? a_q[31] : b_q[31];
        diff     = big[30:23] - sml[30:23];
        sml_full = {2'b01, sml[22:0], 3'b000};
        if (diff >= 8'd27) begin
          msml_d = MANT_W'(1);
        end else begin
          sml_sh    = sml_full >> diff;
          lost_mask = (MANT_W'(1) << diff) - MANT_W'(1);
          msml_d    = {sml_sh[MANT_W-1:1], sml_sh[0] | (|(sml_full & lost_mask))};
        end
        mbig_d    = {2'b01, big[22:0], 3'b000};
        sign_d    = big_sign;
        exp_d     = {1'b0, big[30:23]};
        eff_sub_d = a_q[31] ^ b_q[31];
        cnt_d     = '0;
        state_d   = S_ADD;
      end
      S_ADD: begin
        sum = eff_sub_q ? (mbig_q - msml_q) : (mbig_q + msml_q);
        if (sum == '0) begin
          res_d   = '0;
          state_d = S_DONE;
        end else begin
          if (sum[MANT_W-1]) begin
            sum_adj = {1'b0, sum[MANT_W-1:2], sum[1] | sum[0]};
            exp_d   = exp_q + 9'd1;
          end else begin
            sum_adj = sum;
          end
          mbig_d = sum_adj;
          if (sum_adj[26]) begin
            state_d = S_ROUND;
          end else if (exp_d <= 9'd1) begin
            res_d   = {sign_q, 31'b0};
            state_d = S_DONE;
          end else begin
            state_d = S_NORM;
          end
        end
      end
      S_NORM: begin
        // Look ahead one shift so a normalized mantissa leaves NORM without an idle check cycle.
        nrm    = mbig_q << 1;
        mbig_d = nrm;
        exp_d  = exp_q - 9'd1;
        cnt_d  = cnt_q + CNT_W'(1);
        if (nrm[26] || (32'(cnt_q) + 32'd1 >= MAX_NORM_STEPS)) begin
          state_d = S_ROUND;
        end else if (exp_d <= 9'd1) begin
          res_d   = {sign_q, 31'b0};
          state_d = S_DONE;
        end
      end
      S_ROUND: begin
        rnd_up = mbig_q[2] & (mbig_q[1] | mbig_q[0] | mbig_q[3]);
        rnd    = {1'b0, mbig_q[26:3]} + 25'(rnd_up);
        if (rnd[24]) begin
          rfrac = rnd[23:1];
          rexp  = exp_q + 9'd1;
        end else begin
          rfrac = rnd[22:0];
          rexp  = exp_q;
        end
        if (rexp >= 9'd255) begin
          res_d = sign_q ? NEG_INF : POS_INF;
          ovf_d = 1'b1;
        end else begin
          res_d = {sign_q, rexp[7:0], rfrac};
        end
        state_d = S_DONE;
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      sign_q    <= 1'b0;
      eff_sub_q <= 1'b0;
      exp_q     <= '0;
      mbig_q    <= '0;
      msml_q    <= '0;
      cnt_q     <= '0;
      res_q     <= '0;
      ovf_q     <= 1'b0;
      inv_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      sign_q    <= sign_d;
      eff_sub_q <= eff_sub_d;
      exp_q     <= exp_d;
      mbig_q    <= mbig_d;
      msml_q    <= msml_d;
      cnt_q     <= cnt_d;
      res_q     <= res_d;
      ovf_q     <= ovf_d;
      inv_q     <= inv_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign out       = res_q;
  assign flag_ovf  = ovf_q;
  assign flag_inv  = inv_q;
endmodule
